// File: rtl/ycr1_dmem_wb_bridge.sv
// ycr1_dmem_wb_bridge: terminates one dmem request/response port and turns
// each accepted request into a single Wishbone classic cycle.
//
// Handshake: dmem_req_ack is high whenever the bridge is idle. A request
// transfers on a cycle where dmem_req and dmem_req_ack are both high.
// Exactly one dmem_resp pulse (RDY_OK or RDY_ER) follows each accepted
// request. The initiator holds dmem_req until it is acked.
// On Wishbone, stb/cyc stay high with stable adr/we/sel/dat until ack, err
// or timeout ends the cycle.
module ycr1_dmem_wb_bridge #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          dmem_req_ack,
  input  logic          dmem_req,
  input  logic          dmem_cmd,
  input  logic [1:0]    dmem_width,
  input  logic [AW-1:0] dmem_addr,
  input  logic [31:0]   dmem_wdata,
  output logic [31:0]   dmem_rdata,
  output logic [1:0]    dmem_resp,
  output logic          wbd_stb_o,
  output logic          wbd_cyc_o,
  output logic          wbd_we_o,
  output logic [AW-1:0] wbd_adr_o,
  output logic [31:0]   wbd_dat_o,
  output logic [3:0]    wbd_sel_o,
  input  logic [31:0]   wbd_dat_i,
  input  logic          wbd_ack_i,
  input  logic          wbd_err_i
);

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_OK     = 2'd1;
  localparam logic [1:0] RESP_ER     = 2'd2;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  // Timeout limit as an 8-bit compare value; zero turns the timeout off.
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
  localparam bit         TMO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state;
  logic          cmd_q;
  logic [1:0]    width_q;
  logic [1:0]    off_q;
  logic [AW-1:0] adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic [7:0]    tmo_cnt;
  logic [1:0]    resp_q;
  logic [31:0]   rdata_q;

  logic          req_illegal;
  logic [3:0]    req_sel;
  logic [31:0]   req_dat;
  logic [31:0]   rd_mask;
  logic [31:0]   rd_aligned;
  logic [7:0]    tmo_next;
  logic          tmo_hit;

  // Decode the incoming request: legality, byte selects and lane steering.
  always_comb begin
    req_illegal = 1'b0;
    req_sel     = 4'b0000;
    req_dat     = dmem_wdata << {dmem_addr[1:0], 3'b000};
    case (dmem_width)
      W_BYTE: req_sel = 4'b0001 << dmem_addr[1:0];
      W_HALF: begin
        req_sel     = 4'b0011 << dmem_addr[1:0];
        req_illegal = dmem_addr[0];
      end
      W_WORD: begin
        req_sel     = 4'b1111;
        req_illegal = (dmem_addr[1:0] != 2'b00);
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Right-align and zero-extend the returned bus data for the captured width.
  always_comb begin
    rd_aligned = wbd_dat_i >> {off_q, 3'b000};
    case (width_q)
      W_BYTE:  rd_mask = 32'h0000_00FF;
      W_HALF:  rd_mask = 32'h0000_FFFF;
      default: rd_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Saturating wait counter; the timeout fires on the TIMEOUT-th BUS cycle.
  always_comb begin
    tmo_next = (tmo_cnt == 8'hFF) ? 8'hFF : tmo_cnt + 8'd1;
    tmo_hit  = TMO_EN && (tmo_next == TMO_LIMIT);
  end

  // Main FSM: accept in IDLE, run the Wishbone cycle in BUS, pulse a response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cmd_q   <= 1'b0;
      width_q <= 2'd0;
      off_q   <= 2'd0;
      adr_q   <= '0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      tmo_cnt <= 8'd0;
      resp_q  <= RESP_NOTRDY;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          resp_q  <= RESP_NOTRDY;
          rdata_q <= 32'd0;
          if (dmem_req) begin
            cmd_q   <= dmem_cmd;
            width_q <= dmem_width;
            off_q   <= dmem_addr[1:0];
            adr_q   <= {dmem_addr[AW-1:2], 2'b00};
            dat_q   <= req_dat;
            sel_q   <= req_illegal ? 4'b0000 : req_sel;
            tmo_cnt <= 8'd0;
            if (req_illegal) begin
              // Misaligned or illegal width: answer with an error, no bus cycle.
              resp_q <= RESP_ER;
              state  <= ST_RESP;
            end else begin
              state  <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          tmo_cnt <= tmo_next;
          if (wbd_err_i) begin
            resp_q <= RESP_ER;
            state  <= ST_RESP;
          end else if (wbd_ack_i) begin
            resp_q  <= RESP_OK;
            rdata_q <= cmd_q ? 32'd0 : (rd_aligned & rd_mask);
            state   <= ST_RESP;
          end else if (tmo_hit) begin
            // Abandon the cycle; a late ack lands in RESP/IDLE and is ignored.
            resp_q <= RESP_ER;
            state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          resp_q  <= RESP_NOTRDY;
          rdata_q <= 32'd0;
          state   <= ST_IDLE;
        end
        default: begin
          resp_q  <= RESP_NOTRDY;
          rdata_q <= 32'd0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from registers (state included).
  always_comb begin
    dmem_req_ack = (state == ST_IDLE);
    dmem_resp    = resp_q;
    dmem_rdata   = rdata_q;
    wbd_stb_o    = (state == ST_BUS);
    wbd_cyc_o    = (state == ST_BUS);
    wbd_we_o     = (state == ST_BUS) && cmd_q;
    wbd_adr_o    = adr_q;
    wbd_dat_o    = dat_q;
    wbd_sel_o    = sel_q;
  end

endmodule

// File: tb/tb_ycr1_dmem_wb_bridge.sv
// Testbench for ycr1_dmem_wb_bridge: directed cases from the block's feature
// list plus randomized transactions against a behavioural model.
module tb_ycr1_dmem_wb_bridge;

  localparam int AW = 32;
  localparam int TO = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          dmem_req_ack;
  logic          dmem_req;
  logic          dmem_cmd;
  logic [1:0]    dmem_width;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [31:0]   dmem_rdata;
  logic [1:0]    dmem_resp;
  logic          wbd_stb_o;
  logic          wbd_cyc_o;
  logic          wbd_we_o;
  logic [AW-1:0] wbd_adr_o;
  logic [31:0]   wbd_dat_o;
  logic [3:0]    wbd_sel_o;
  logic [31:0]   wbd_dat_i;
  logic          wbd_ack_i;
  logic          wbd_err_i;

  ycr1_dmem_wb_bridge #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_req_ack (dmem_req_ack),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .wbd_stb_o    (wbd_stb_o),
    .wbd_cyc_o    (wbd_cyc_o),
    .wbd_we_o     (wbd_we_o),
    .wbd_adr_o    (wbd_adr_o),
    .wbd_dat_o    (wbd_dat_o),
    .wbd_sel_o    (wbd_sel_o),
    .wbd_dat_i    (wbd_dat_i),
    .wbd_ack_i    (wbd_ack_i),
    .wbd_err_i    (wbd_err_i)
  );

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];   // {resp, rdata} expected per accepted request
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  bit in_resp = 1'b0;      // bench knows the bridge is in its response cycle
  int resp_cyc[3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_illegal(input logic [1:0] w, input logic [1:0] a);
    return (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a != 2'd0);
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] w, input logic [1:0] a);
    case (w)
      2'd0:    return 4'(1 << a);
      2'd1:    return 4'(3 << a);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_mask(input logic [1:0] w);
    case (w)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic check_resp(input string tag);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check(tag, {30'd0, dmem_resp, dmem_rdata}, {30'd0, e});
    end
  endtask

  // ---------------- driver ----------------
  // mode: 0 ack, 1 err, 2 ack+err together, 3 no answer (timeout + late ack)
  task automatic txn(input logic cmd, input logic [1:0] width, input logic [31:0] addr,
                     input logic [31:0] wdata, input int mode, input int waits,
                     input logic [31:0] bus_rdata);
    logic [1:0]  a;
    bit          bad;
    logic [1:0]  e_resp;
    logic [31:0] e_rd;
    int          acc_cyc;
    a      = addr[1:0];
    bad    = m_illegal(width, a);
    e_resp = (bad || mode != 0) ? 2'd2 : 2'd1;
    e_rd   = (e_resp == 2'd1 && !cmd) ? ((bus_rdata >> (8 * int'(a))) & m_mask(width)) : 32'd0;
    exp_q.push_back({e_resp, e_rd});

    dmem_req   = 1'b1;
    dmem_cmd   = cmd;
    dmem_width = width;
    dmem_addr  = addr;
    dmem_wdata = wdata;
    if (in_resp) begin
      check("ack_in_resp", 64'(dmem_req_ack), 64'(0));
      tick();
      check("resp_one_cycle", 64'(dmem_resp), 64'(0));
    end
    check("req_ack", 64'(dmem_req_ack), 64'(1));
    acc_cyc = cyc_cnt;
    tick();
    dmem_req   = 1'b0;
    dmem_wdata = $urandom;

    if (bad) begin
      check("bad_no_stb", 64'(wbd_stb_o), 64'(0));
      check_resp("bad_resp");
      in_resp = 1'b1;
      return;
    end

    check("adr", 64'(wbd_adr_o), 64'({addr[31:2], 2'b00}));
    check("sel", 64'(wbd_sel_o), 64'(m_sel(width, a)));
    check("dat", 64'(wbd_dat_o), 64'(32'(wdata << (8 * int'(a)))));
    check("we", 64'(wbd_we_o), 64'(cmd));
    check("cyc_eq_stb", 64'(wbd_cyc_o), 64'(wbd_stb_o));

    if (mode == 3) begin
      for (int i = 0; i < TO; i++) begin
        check("tmo_stb_hi", 64'(wbd_stb_o), 64'(1));
        check("tmo_notrdy", 64'(dmem_resp), 64'(0));
        tick();
      end
      check("tmo_stb_lo", 64'(wbd_stb_o), 64'(0));
      check_resp("tmo_resp");
      tick();
      check("tmo_idle", 64'(dmem_resp), 64'(0));
      tick();
      wbd_ack_i = 1'b1;
      wbd_dat_i = bus_rdata;
      tick();
      wbd_ack_i = 1'b0;
      check("late_ack_resp", 64'(dmem_resp), 64'(0));
      check("late_ack_stb", 64'(wbd_stb_o), 64'(0));
      check("late_ack_idle", 64'(dmem_req_ack), 64'(1));
      in_resp = 1'b0;
      return;
    end

    for (int i = 0; i < waits; i++) begin
      check("wait_stb", 64'(wbd_stb_o), 64'(1));
      check("wait_notrdy", 64'(dmem_resp), 64'(0));
      tick();
    end
    check("ack_stb", 64'(wbd_stb_o), 64'(1));
    wbd_ack_i = (mode != 1);
    wbd_err_i = (mode != 0);
    wbd_dat_i = bus_rdata;
    tick();
    wbd_ack_i = 1'b0;
    wbd_err_i = 1'b0;
    wbd_dat_i = $urandom;
    check_resp("bus_resp");
    check("latency", 64'(cyc_cnt - acc_cyc), 64'(waits + 2));
    in_resp = 1'b1;
  endtask

  task automatic reset_mid_bus();
    dmem_req   = 1'b1;
    dmem_cmd   = 1'b0;
    dmem_width = 2'd2;
    dmem_addr  = 32'h0000_0040;
    if (in_resp) tick();
    tick();
    dmem_req = 1'b0;
    tick();
    tick();
    check("rst_pre_stb", 64'(wbd_stb_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst_stb", 64'(wbd_stb_o), 64'(0));
    check("rst_cyc", 64'(wbd_cyc_o), 64'(0));
    check("rst_resp", 64'(dmem_resp), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_req_ack", 64'(dmem_req_ack), 64'(1));
    check("rst_no_resp", 64'(dmem_resp), 64'(0));
    check("rst_stb_after", 64'(wbd_stb_o), 64'(0));
    in_resp = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    dmem_req   = 1'b0;
    dmem_cmd   = 1'b0;
    dmem_width = 2'd0;
    dmem_addr  = '0;
    dmem_wdata = 32'd0;
    wbd_dat_i  = 32'd0;
    wbd_ack_i  = 1'b0;
    wbd_err_i  = 1'b0;
    tick();
    tick();
    check("reset_req_ack", 64'(dmem_req_ack), 64'(1));
    check("reset_resp", 64'(dmem_resp), 64'(0));
    check("reset_rdata", 64'(dmem_rdata), 64'(0));
    check("reset_stb", 64'(wbd_stb_o), 64'(0));
    check("reset_cyc", 64'(wbd_cyc_o), 64'(0));
    check("reset_we", 64'(wbd_we_o), 64'(0));
    check("reset_adr", 64'(wbd_adr_o), 64'(0));
    check("reset_dat", 64'(wbd_dat_o), 64'(0));
    check("reset_sel", 64'(wbd_sel_o), 64'(0));
    rst_n = 1'b1;
    tick();

    // word write / read back
    txn(1'b1, 2'd2, 32'h0001_0008, 32'hDEADBEEF, 0, 0, 32'h0);
    txn(1'b0, 2'd2, 32'h0001_0008, 32'h0, 0, 0, 32'hDEADBEEF);
    // byte and halfword lanes
    txn(1'b1, 2'd0, 32'h0001_0003, 32'h0000_005A, 0, 0, 32'h0);
    txn(1'b0, 2'd1, 32'h0001_0002, 32'h0, 0, 0, 32'h1234ABCD);
    txn(1'b0, 2'd0, 32'h0001_0001, 32'h0, 0, 1, 32'h1234ABCD);
    // misalignment and illegal width
    txn(1'b0, 2'd2, 32'h0001_0001, 32'h0, 0, 0, 32'h0);
    txn(1'b1, 2'd1, 32'h0001_0003, 32'hFFFF, 0, 0, 32'h0);
    txn(1'b0, 2'd3, 32'h0001_0000, 32'h0, 0, 0, 32'h0);
    // wait states and errors
    txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 0, 5, 32'hCAFEF00D);
    txn(1'b0, 2'd2, 32'h0000_0104, 32'h0, 2, 0, 32'h11111111);
    txn(1'b1, 2'd2, 32'h0000_0108, 32'h22222222, 1, 2, 32'h0);
    // timeout with a late ack
    txn(1'b0, 2'd2, 32'h0000_0200, 32'h0, 3, 0, 32'h33333333);
    // reset during a bus wait
    reset_mid_bus();
    // back-to-back zero-wait reads
    for (int k = 0; k < 3; k++) begin
      txn(1'b0, 2'd2, 32'h0000_0300 + 32'(4 * k), 32'h0, 0, 0, 32'hA0A0_0000 + 32'(k));
      resp_cyc[k] = cyc_cnt;
    end
    check("b2b_gap0", 64'(resp_cyc[1] - resp_cyc[0]), 64'(3));
    check("b2b_gap1", 64'(resp_cyc[2] - resp_cyc[1]), 64'(3));

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int r;
      int md;
      r  = int'($urandom_range(0, 9));
      md = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 0 : 3;
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
          md, int'($urandom_range(0, TO - 2)), $urandom);
    end
    tick();
    check("end_queue_empty", 64'(exp_q.size()), 64'(0));
    check("end_idle", 64'(dmem_req_ack), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
